// File: rtl/issue_ctrl.sv
// Single-entry issue stage: holds one decoded instruction, tracks pending destination
// registers and the in-flight count, and issues to one of four FUs. Optional macro: ISSUE_CTRL_WB_BYPASS_EN.
module issue_ctrl #(
    parameter int unsigned NR_INFLIGHT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        decoded_valid_i,
    output logic        decoded_ready_o,
    input  logic [3:0]  fu_i,
    input  logic [7:0]  op_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [4:0]  rd_i,
    input  logic [63:0] pc_i,
    output logic [3:0]  issue_valid_o,
    input  logic [3:0]  fu_ready_i,
    output logic [7:0]  issue_op_o,
    output logic [4:0]  issue_rs1_o,
    output logic [4:0]  issue_rs2_o,
    output logic [4:0]  issue_rd_o,
    output logic [63:0] issue_pc_o,
    input  logic        wb_valid_i,
    input  logic [4:0]  wb_rd_i,
    output logic [31:0] busy_o,
    output logic [3:0]  inflight_o
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] HOLD     = 2'd1;
    localparam logic [1:0] CSR_WAIT = 2'd2;

    localparam logic [3:0] FU_NONE = 4'd0;
    localparam logic [3:0] FU_ALU  = 4'd1;
    localparam logic [3:0] FU_MULT = 4'd2;
    localparam logic [3:0] FU_LSU  = 4'd3;
    localparam logic [3:0] FU_CSR  = 4'd4;

    logic [1:0]  state;
    logic [3:0]  hold_fu;
    logic [31:0] busy_chk;
    logic [3:0]  inflight_chk;
    logic        hazard;
    logic        count_ok;
    logic        can_issue;
    logic        fire;
    logic        retire;
    logic        wb_dec;
    logic [31:0] busy_nxt;

    // Hazard and capacity view; the bypass build lets a same-cycle writeback free its register and slot.
    always_comb begin
        busy_chk     = busy_o;
        inflight_chk = inflight_o;
`ifdef ISSUE_CTRL_WB_BYPASS_EN
        if (wb_valid_i) begin
            busy_chk[wb_rd_i] = 1'b0;
            if (inflight_o != 4'd0)
                inflight_chk = inflight_o - 4'd1;
        end
`endif
    end

    always_comb begin
        hazard = ((issue_rs1_o != 5'd0) && busy_chk[issue_rs1_o]) ||
                 ((issue_rs2_o != 5'd0) && busy_chk[issue_rs2_o]) ||
                 ((issue_rd_o  != 5'd0) && busy_chk[issue_rd_o]);
        if (hold_fu == FU_CSR)
            count_ok = (inflight_chk == 4'd0);
        else
            count_ok = (32'(inflight_chk) < NR_INFLIGHT);
        can_issue = (state == HOLD) && !flush_i && !hazard && count_ok;
        issue_valid_o = '0;
        if (can_issue) begin
            case (hold_fu)
                FU_ALU:  issue_valid_o = 4'b0001;
                FU_MULT: issue_valid_o = 4'b0010;
                FU_LSU:  issue_valid_o = 4'b0100;
                FU_CSR:  issue_valid_o = 4'b1000;
                default: issue_valid_o = '0;
            endcase
        end
        fire   = |(issue_valid_o & fu_ready_i);
        retire = (state == HOLD) && ((hold_fu == FU_NONE) || (hold_fu > FU_CSR));
        wb_dec = wb_valid_i && (inflight_o != 4'd0);
    end

    assign decoded_ready_o = (state == IDLE) && !flush_i;

    // Writeback clears first so a same-register issue in the same cycle keeps the bit set.
    always_comb begin
        busy_nxt = busy_o;
        if (wb_valid_i)
            busy_nxt[wb_rd_i] = 1'b0;
        if (fire && (issue_rd_o != 5'd0))
            busy_nxt[issue_rd_o] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            hold_fu     <= FU_NONE;
            issue_op_o  <= '0;
            issue_rs1_o <= '0;
            issue_rs2_o <= '0;
            issue_rd_o  <= '0;
            issue_pc_o  <= '0;
            busy_o      <= '0;
            inflight_o  <= '0;
        end else if (flush_i) begin
            state       <= IDLE;
            hold_fu     <= FU_NONE;
            issue_op_o  <= '0;
            issue_rs1_o <= '0;
            issue_rs2_o <= '0;
            issue_rd_o  <= '0;
            issue_pc_o  <= '0;
            busy_o      <= '0;
            inflight_o  <= '0;
        end else begin
            busy_o <= busy_nxt;
            if (fire && !wb_dec)
                inflight_o <= inflight_o + 4'd1;
            else if (wb_dec && !fire)
                inflight_o <= inflight_o - 4'd1;

            case (state)
                IDLE: begin
                    if (decoded_valid_i) begin
                        state       <= HOLD;
                        hold_fu     <= fu_i;
                        issue_op_o  <= op_i;
                        issue_rs1_o <= rs1_i;
                        issue_rs2_o <= rs2_i;
                        issue_rd_o  <= rd_i;
                        issue_pc_o  <= pc_i;
                    end
                end
                HOLD: begin
                    if (retire)
                        state <= IDLE;
                    else if (fire)
                        state <= (hold_fu == FU_CSR) ? CSR_WAIT : IDLE;
                end
                CSR_WAIT: begin
                    if (wb_valid_i)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
